// File: rtl/pe_input_sequencer.sv
// ============================================================================
// pe_input_sequencer: buffers an N-sample frame, then issues N/4 radix-4
// groups (x[k], x[k+N/4], x[k+N/2], x[k+3N/4]) with twiddle index k.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pe_input_sequencer #(
   parameter int WORDSIZE = 16,
   parameter int N        = 16,
   localparam int AW      = $clog2(N),
   localparam int KW      = (N > 4) ? $clog2(N / 4) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WORDSIZE-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [WORDSIZE-1:0] out0,
   output logic [WORDSIZE-1:0] out1,
   output logic [WORDSIZE-1:0] out2,
   output logic [WORDSIZE-1:0] out3,
   output logic [KW-1:0]       tw_idx,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last
);

   localparam logic [AW-1:0] c_last_wr = AW'(N - 1);
   localparam logic [KW-1:0] c_last_k  = KW'(N / 4 - 1);
   localparam logic [AW-1:0] c_q1      = AW'(N / 4);
   localparam logic [AW-1:0] c_q2      = AW'(N / 2);
   localparam logic [AW-1:0] c_q3      = AW'(3 * N / 4);

   typedef enum logic [0:0] {
      LOAD  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       wr_cnt_q, wr_cnt_d;
   logic [KW-1:0]       rd_cnt_q, rd_cnt_d;
   logic [WORDSIZE-1:0] mem_q [N];
   logic                wr_en;
   logic [AW-1:0]       rd_base;

   // rd_cnt < N/4, so the quarter-frame offsets never wrap the address
   assign rd_base = AW'(rd_cnt_q);

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      wr_en     = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      tw_idx    = '0;
      out0      = '0;
      out1      = '0;
      out2      = '0;
      out3      = '0;
      case (state_q)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en = 1'b1;
               if (wr_cnt_q == c_last_wr) begin
                  wr_cnt_d = '0;
                  state_d  = ISSUE;
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         ISSUE: begin
            out_valid = 1'b1;
            out0      = mem_q[rd_base];
            out1      = mem_q[rd_base + c_q1];
            out2      = mem_q[rd_base + c_q2];
            out3      = mem_q[rd_base + c_q3];
            tw_idx    = rd_cnt_q;
            out_last  = (rd_cnt_q == c_last_k);
            if (out_ready) begin
               if (out_last) begin
                  rd_cnt_d = '0;
                  state_d  = LOAD;
               end else begin
                  rd_cnt_d = rd_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LOAD;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   // Frame buffer holds no reset: stale contents are never visible outside ISSUE
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_cnt_q] <= in_data;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pe_input_sequencer.sv
// ============================================================================
// tb_pe_input_sequencer: self-checking bench for pe_input_sequencer (N=16).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pe_input_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out0, out1, out2, out3;
   logic [1:0]  tw_idx;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   int vectors = 0;
   int errors  = 0;

   logic [15:0] frame [16];
   logic [68:0] obs;
   localparam logic [68:0] c_idle = {1'b0, 1'b1, 67'b0};

   pe_input_sequencer #(.WORDSIZE(16), .N(16)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
      .tw_idx(tw_idx), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   assign obs = {out_valid, in_ready, out0, out1, out2, out3, tw_idx, out_last};

   // Reference: group k of a frame takes every quarter-frame stride from k
   function automatic logic [68:0] exp_group(input int k);
      logic [15:0] s [4];
      for (int j = 0; j < 4; j++) s[j] = frame[k + j * 4];
      return {1'b1, 1'b0, s[0], s[1], s[2], s[3], 2'(k), (k == 3)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sample(input logic [15:0] d);
      bit acc = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int c = 0; c < 50 && !acc; c++) begin
         if (in_ready) acc = 1;
         tick();
      end
      in_valid = 1'b0;
      if (!acc) begin
         vectors++;
         errors++;
         $display("FAIL accept_timeout data=%h in_ready=%b required=1", d, in_ready);
      end
   endtask

   task automatic send_range(input int lo, input int hi, input bit gaps);
      for (int i = lo; i <= hi; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            tick();
         end
         send_sample(frame[i]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      tick();
      vectors++;
      if (obs !== c_idle) begin
         errors++; $display("FAIL reset_during obs=%h required=%h", obs, c_idle);
      end
      tick();
      rst = 1'b0;
      tick();
      vectors++;
      if (obs !== c_idle) begin
         errors++; $display("FAIL reset_after obs=%h required=%h", obs, c_idle);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) frame[i] = 16'(i);
      send_range(0, 14, 0);
      in_valid = 1'b1; in_data = frame[15];
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL basic_pre_last out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (obs !== exp_group(k)) begin
            errors++; $display("FAIL basic_g%0d obs=%h required=%h", k, obs, exp_group(k));
         end
         tick();
      end
      vectors++;
      if (obs !== c_idle) begin
         errors++; $display("FAIL basic_end obs=%h required=%h", obs, c_idle);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 16; i++) frame[i] = 16'($urandom);
      out_ready = 1'b1;
      send_range(0, 15, 0);
      vectors++;
      if (obs !== exp_group(0)) begin
         errors++; $display("FAIL bp_g0 obs=%h required=%h", obs, exp_group(0));
      end
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         vectors++;
         if (obs !== exp_group(1)) begin
            errors++; $display("FAIL bp_hold_c%0d obs=%h required=%h", c, obs, exp_group(1));
         end
         tick();
      end
      out_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         vectors++;
         if (obs !== exp_group(k)) begin
            errors++; $display("FAIL bp_release_g%0d obs=%h required=%h", k, obs, exp_group(k));
         end
         tick();
      end
      vectors++;
      if (obs !== c_idle) begin
         errors++; $display("FAIL bp_end obs=%h required=%h", obs, c_idle);
      end
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 16; i++) frame[i] = 16'h1000 + 16'(i);
      out_ready = 1'b1;
      send_range(0, 15, 1);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (obs !== exp_group(k)) begin
            errors++; $display("FAIL gaps_g%0d obs=%h required=%h", k, obs, exp_group(k));
         end
         tick();
      end
   endtask

   task automatic test_ignored_input();
      for (int i = 0; i < 16; i++) frame[i] = 16'($urandom_range(0, 16'hFFFE));
      out_ready = 1'b1;
      send_range(0, 15, 0);
      in_valid = 1'b1; in_data = 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (obs !== exp_group(k)) begin
            errors++; $display("FAIL ignore_g%0d obs=%h required=%h", k, obs, exp_group(k));
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) send_sample(16'hAA00 + 16'(i));
      rst = 1'b1;
      tick();
      vectors++;
      if (obs !== c_idle) begin
         errors++; $display("FAIL rstload_during obs=%h required=%h", obs, c_idle);
      end
      rst = 1'b0;
      for (int i = 0; i < 16; i++) frame[i] = 16'h0020 + 16'(i);
      send_range(0, 15, 0);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (obs !== exp_group(k)) begin
            errors++; $display("FAIL rstload_g%0d obs=%h required=%h", k, obs, exp_group(k));
         end
         tick();
      end
      // Reset while groups are still pending
      for (int i = 0; i < 16; i++) frame[i] = 16'($urandom);
      send_range(0, 15, 0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (obs !== c_idle) begin
         errors++; $display("FAIL rstissue_after obs=%h required=%h", obs, c_idle);
      end
      for (int i = 0; i < 16; i++) frame[i] = 16'($urandom);
      send_range(0, 15, 0);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (obs !== exp_group(k)) begin
            errors++; $display("FAIL rstissue_g%0d obs=%h required=%h", k, obs, exp_group(k));
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 16; i++) frame[i] = 16'(f * 16'h4000) + 16'($urandom_range(0, 16'h3FFF));
         send_range(0, 15, 0);
         for (int k = 0; k < 4; k++) begin
            vectors++;
            if (obs !== exp_group(k)) begin
               errors++; $display("FAIL b2b_f%0d_g%0d obs=%h required=%h", f, k, obs, exp_group(k));
            end
            tick();
         end
         vectors++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_f%0d in_ready=%b required=1", f, in_ready);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] q [$];
      int k = 0;
      int done = 0;
      for (int c = 0; c < 2000 && done < 4; c++) begin
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         in_data   = 16'($urandom);
         vectors++;
         if (q.size() < 16) begin
            if (obs !== c_idle) begin
               errors++; $display("FAIL rand_load c%0d obs=%h required=%h", c, obs, c_idle);
            end
            if (in_valid) begin
               q.push_back(in_data);
               if (q.size() == 16)
                  for (int i = 0; i < 16; i++) frame[i] = q[i];
            end
         end else begin
            if (obs !== exp_group(k)) begin
               errors++; $display("FAIL rand_issue c%0d obs=%h required=%h", c, obs, exp_group(k));
            end
            if (out_ready) begin
               k++;
               if (k == 4) begin
                  k = 0; q.delete(); done++;
               end
            end
         end
         tick();
      end
      vectors++;
      if (done != 4) begin
         errors++; $display("FAIL rand_timeout frames=%0d required=4", done);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gaps();
      test_ignored_input();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pe_input_sequencer.md
# pe_input_sequencer

Upstream feeder for the radix-4 butterfly `pe`. It accepts a stream of N fixed-point samples, one per handshake, into an internal frame buffer. It then issues N/4 butterfly groups (x[k], x[k+N/4], x[k+N/2], x[k+3N/4]), each with the twiddle index k. Its outputs connect directly to the pe in0..in3 ports and to the twiddle lookup.

## Interface
- WORDSIZE, 16, sample width (Q5.10 fixed-point, WL=16, IWL=5, FWL=10; passed through unmodified).
- N, 16, frame length. Must be a power of 4 and ≥4.
- Derived: AW = log2(N); KW = max(1, log2(N/4)).

- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous and active-high.
- in_data  in  WORDSIZE  input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a sample this cycle.
- out0, out1, out2, out3  out  WORDSIZE each  group samples x[k], x[k+N/4], x[k+N/2], x[k+3N/4].
- tw_idx  out  KW  twiddle index k of the current group.
- out_valid  out  1  group outputs are valid.
- out_ready  in  1  downstream consumes the group this cycle.
- out_last  out  1  current group is k = N/4−1.

## Operation
- Two states: LOAD and ISSUE. Counters: wr_cnt (AW bits) and rd_cnt (KW bits). Buffer: N×WORDSIZE register array; contents are not reset.
- LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: mem[wr_cnt]<=in_data; wr_cnt++.
  - Accepting with wr_cnt==N−1 gives wr_cnt<=0, state<=ISSUE.
- ISSUE:
  - in_ready=0; in_valid is ignored and no write occurs. out_valid=1.
  - out0..out3 are combinational reads: mem[rd_cnt], mem[rd_cnt+N/4], mem[rd_cnt+N/2], mem[rd_cnt+3N/4].
  - tw_idx=rd_cnt. out_last=(rd_cnt==N/4−1).
  - On out_valid&&out_ready: rd_cnt++.
  - If out_last is high at that handshake, rd_cnt<=0 and state<=LOAD.
- Output value outside ISSUE: out0..out3, tw_idx and out_last are forced to 0 whenever out_valid=0.
- Arithmetic: none on data; samples are bit-exact copies. Index adds use the constant offsets N/4, N/2, 3N/4 on AW bits and never overflow, since rd_cnt<N/4.

## Timing
- Reset: state=LOAD, wr_cnt=0, rd_cnt=0. Effective the cycle after the rst-high edge.
- Outputs at and after reset: in_ready=1, out_valid=0, out0..out3=0, tw_idx=0, out_last=0.
- rst mid-LOAD or mid-ISSUE: the partial frame is discarded, ungranted groups are dropped, and the block returns to LOAD.
- Latency: the last sample is accepted at edge t. out_valid=1 with group 0 during the cycle after edge t.
- Throughput: N accept cycles plus N/4 issue cycles per frame with no backpressure. No overlap between load and issue.
- Backpressure: with out_ready=0, out0..out3, tw_idx and out_last hold stable and out_valid stays 1.
- End of frame: the final group handshake at edge t gives in_ready=1 in the cycle after t. A sample presented then is accepted as x[0] of the next frame.
- in_valid gaps in LOAD: wr_cnt holds and no write occurs.
- out_ready asserted in LOAD has no effect.

## Test plan
- Basic frame, N=16, WORDSIZE=16: stream 0x0000..0x000F with in_valid=1 and out_ready=1.
  - Required groups, in order: (0,4,8,C) tw_idx=0; (1,5,9,D) tw_idx=1; (2,6,A,E) tw_idx=2; (3,7,B,F) tw_idx=3.
  - out_last=1 only on the 4th group. out_valid rises exactly 1 cycle after the 16th accept.
- Backpressure: hold out_ready=0 for 5 cycles while group 1 is presented.
  - Outputs stay (1,5,9,D), tw_idx=1, out_valid=1, in_ready=0.
  - Release out_ready → group 2 appears next cycle.
- Input gaps: toggle in_valid every other cycle with samples 0x1000..0x100F.
  - Group 0 = (0x1000,0x1004,0x1008,0x100C).
  - No sample is lost or duplicated.
- Ignored input in ISSUE: drive in_valid=1 with 0xFFFF throughout ISSUE.
  - All 4 groups match the loaded frame; in_ready=0 for all 4 ISSUE cycles.
- Reset mid-operation: assert rst after 7 accepts, then load a fresh frame 0x0020..0x002F.
  - Group 0 = (0x20,0x24,0x28,0x2C).
  - During and after rst, out_valid=0 and all outputs are 0.
- Back-to-back frames: load frame A, drain it, then immediately load frame B.
  - in_ready=1 in the cycle after the final A group handshake.
  - Frame B groups contain no frame-A data.
